// File: rtl/apb_gpio_bank.sv
// APB GPIO bank: per-bit direction, atomic set/clear, synchronised inputs and
// edge interrupts with write-1-to-clear status, plus programmable wait states.
module apb_gpio_bank #(
    parameter int unsigned GPIO_WIDTH  = 8,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic [31:0]           PWDATA,
    input  logic [3:0]            PSTRB,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    localparam int unsigned W     = GPIO_WIDTH;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [2:0] REG_DOUT  = 3'd0;
    localparam logic [2:0] REG_DIR   = 3'd1;
    localparam logic [2:0] REG_DIN   = 3'd2;
    localparam logic [2:0] REG_IEN   = 3'd3;
    localparam logic [2:0] REG_ITYPE = 3'd4;
    localparam logic [2:0] REG_ISTAT = 3'd5;
    localparam logic [2:0] REG_SET   = 3'd6;
    localparam logic [2:0] REG_CLR   = 3'd7;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pready_q, pready_d;
    logic             pslverr_q, pslverr_d;
    logic [31:0]      prdata_q, prdata_d;
    logic [W-1:0]     dout_q, dout_d;
    logic [W-1:0]     dir_q, dir_d;
    logic [W-1:0]     ien_q, ien_d;
    logic [W-1:0]     itype_q, itype_d;
    logic [W-1:0]     istat_q, istat_d;
    logic [W-1:0]     sync1_q, sync1_d;
    logic [W-1:0]     sync_q, sync_d;
    logic [W-1:0]     prev_q, prev_d;

    logic [2:0]       sel;
    logic             access_err;
    logic [31:0]      lane_mask;
    logic [W-1:0]     wbits;
    logic [W-1:0]     wen;
    logic [W-1:0]     hw_set;
    logic             commit;
    logic             final_d;
    logic [31:0]      rd_data;

    // Address decode, error detection and byte-lane masking
    always_comb begin
        sel        = PADDR[4:2];
        access_err = (|PADDR[1:0]) || (|PADDR[ADDR_W-1:5])
                   || (PWRITE && (sel == REG_DIN))
                   || (!PWRITE && ((sel == REG_SET) || (sel == REG_CLR)));
        lane_mask  = '0;
        for (int n = 0; n < 4; n++) begin
            lane_mask[8*n +: 8] = {8{PSTRB[n]}};
        end
        wbits  = W'(PWDATA & lane_mask);
        wen    = W'(lane_mask);
        hw_set = ien_q & (((sync_q & ~prev_q) & ~itype_q) | ((~sync_q & prev_q) & itype_q));
        commit = (state_q == ST_ACCESS) && (cnt_q == '0) && PWRITE && !access_err;
    end

    // Register file next state; hardware IRQ set overrides a same-cycle W1C
    always_comb begin
        dout_d  = dout_q;
        dir_d   = dir_q;
        ien_d   = ien_q;
        itype_d = itype_q;
        istat_d = istat_q | hw_set;
        sync1_d = gpio_in;
        sync_d  = sync1_q;
        prev_d  = sync_q;
        if (commit) begin
            case (sel)
                REG_DOUT:  dout_d  = (dout_q & ~wen) | wbits;
                REG_DIR:   dir_d   = (dir_q & ~wen) | wbits;
                REG_IEN:   ien_d   = (ien_q & ~wen) | wbits;
                REG_ITYPE: itype_d = (itype_q & ~wen) | wbits;
                REG_ISTAT: istat_d = (istat_q & ~wbits) | hw_set;
                REG_SET:   dout_d  = dout_q | wbits;
                REG_CLR:   dout_d  = dout_q & ~wbits;
                default:   dout_d  = dout_q;
            endcase
        end
    end

    // Read data is taken from next-state values so the registered PRDATA
    // shows the register contents of the cycle in which PREADY is high.
    always_comb begin
        case (sel)
            REG_DOUT:  rd_data = 32'(dout_d);
            REG_DIR:   rd_data = 32'(dir_d);
            REG_DIN:   rd_data = 32'(sync_d);
            REG_IEN:   rd_data = 32'(ien_d);
            REG_ITYPE: rd_data = 32'(itype_d);
            REG_ISTAT: rd_data = 32'(istat_d);
            default:   rd_data = '0;
        endcase
    end

    // APB state machine; the response flops load one cycle ahead of completion
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        final_d   = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ST_SETUP;
                    cnt_d   = WAIT_INIT;
                end
            end
            ST_SETUP: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACCESS;
                    final_d = (cnt_q == '0);
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    final_d = (cnt_q == CNT_W'(1));
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (final_d) begin
            pready_d  = 1'b1;
            pslverr_d = access_err;
            prdata_d  = (access_err || PWRITE) ? 32'h0 : rd_data;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            dout_q    <= '0;
            dir_q     <= '0;
            ien_q     <= '0;
            itype_q   <= '0;
            istat_q   <= '0;
            sync1_q   <= '0;
            sync_q    <= '0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            dout_q    <= dout_d;
            dir_q     <= dir_d;
            ien_q     <= ien_d;
            itype_q   <= itype_d;
            istat_q   <= istat_d;
            sync1_q   <= sync1_d;
            sync_q    <= sync_d;
            prev_q    <= prev_d;
        end
    end

    assign PREADY   = pready_q;
    assign PSLVERR  = pslverr_q;
    assign PRDATA   = prdata_q;
    assign gpio_out = dout_q;
    assign gpio_oe  = dir_q;
    assign irq      = |(istat_q & ien_q);

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Bench for apb_gpio_bank: two instances (16 pins / 3 wait states, 8 pins / 0
// wait states) checked against a behavioural register-map model.
module tb_apb_gpio_bank;

    localparam int unsigned WS0 = 3;
    localparam int unsigned WS1 = 0;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        psel0, psel1, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out0, gpio_oe0;
    logic [7:0]  gpio_out1, gpio_oe1;
    logic        irq0, irq1;

    apb_gpio_bank #(.GPIO_WIDTH(16), .ADDR_W(12), .WAIT_STATES(WS0)) u_dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata0),
        .PREADY(pready0), .PSLVERR(pslverr0), .gpio_in(gpio_in),
        .gpio_out(gpio_out0), .gpio_oe(gpio_oe0), .irq(irq0));

    apb_gpio_bank #(.GPIO_WIDTH(8), .ADDR_W(12), .WAIT_STATES(WS1)) u_dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel1), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata1),
        .PREADY(pready1), .PSLVERR(pslverr1), .gpio_in(gpio_in[7:0]),
        .gpio_out(gpio_out1), .gpio_oe(gpio_oe1), .irq(irq1));

    always #5 PCLK = ~PCLK;

    int n_pass = 0;
    int n_chk  = 0;
    logic chk_en   = 1'b0;
    logic pin_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    endtask

    // Behavioural model: register contents and the pin sample history
    logic [31:0] m_dout[2], m_dir[2], m_ien[2], m_itype[2], m_istat[2], m_hwset[2];
    logic [31:0] s0, s1, s2;

    function automatic logic [31:0] wm(input int i);
        return (i == 0) ? 32'h0000_FFFF : 32'h0000_00FF;
    endfunction

    function automatic logic is_err(input logic [11:0] a, input logic w);
        return (a[1:0] != 2'b00) || (a[11:5] != 7'd0) || (w && a[4:0] == 5'h08)
            || (!w && (a[4:0] == 5'h18 || a[4:0] == 5'h1C));
    endfunction

    function automatic logic [31:0] m_read(input int i, input logic [11:0] a);
        case (a[4:2])
            3'd0: return m_dout[i];
            3'd1: return m_dir[i];
            3'd2: return s1 & wm(i);
            3'd3: return m_ien[i];
            3'd4: return m_itype[i];
            3'd5: return m_istat[i];
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input int i, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m, v;
        m = 32'h0;
        for (int n = 0; n < 4; n++) if (s[n]) m = m | (32'hFF << (8 * n));
        v = d & m & wm(i);
        m = m & wm(i);
        case (a[4:2])
            3'd0: m_dout[i]  = (m_dout[i] & ~m) | v;
            3'd1: m_dir[i]   = (m_dir[i] & ~m) | v;
            3'd3: m_ien[i]   = (m_ien[i] & ~m) | v;
            3'd4: m_itype[i] = (m_itype[i] & ~m) | v;
            3'd5: m_istat[i] = m_istat[i] & ~(v & ~m_hwset[i]);
            3'd6: m_dout[i]  = m_dout[i] | v;
            3'd7: m_dout[i]  = m_dout[i] & ~v;
            default: ;
        endcase
    endtask

    // Edge detection on the synchronised history, then shift in the new sample
    always @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < 2; i++) begin
                m_dout[i] = 0; m_dir[i] = 0; m_ien[i] = 0;
                m_itype[i] = 0; m_istat[i] = 0; m_hwset[i] = 0;
            end
            s0 = 0; s1 = 0; s2 = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_hwset[i] = m_ien[i] & wm(i)
                           & (((s1 & ~s2) & ~m_itype[i]) | ((~s1 & s2) & m_itype[i]));
                m_istat[i] = m_istat[i] | m_hwset[i];
            end
            s2 = s1;
            s1 = s0;
            s0 = {16'h0, gpio_in};
        end
    end

    always @(negedge PCLK) begin
        if (!PRESET && chk_en) begin
            chk("gpio_out0", 32'(gpio_out0), m_dout[0]);
            chk("gpio_oe0",  32'(gpio_oe0),  m_dir[0]);
            chk("irq0",      32'(irq0),      32'(|(m_istat[0] & m_ien[0])));
            chk("gpio_out1", 32'(gpio_out1), m_dout[1]);
            chk("gpio_oe1",  32'(gpio_oe1),  m_dir[1]);
            chk("irq1",      32'(irq1),      32'(|(m_istat[1] & m_ien[1])));
        end
    end

    initial begin
        forever begin
            @(posedge PCLK);
            #2;
            if (pin_rand && $urandom_range(0, 3) == 0) gpio_in = 16'($urandom);
        end
    end

    // One APB transfer; called just after a rising edge, returns just after the completing edge
    task automatic xfer(input int i, input logic w, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic err, output int cyc);
        logic        rdy;
        logic        exp_err;
        int          exp_cyc;
        exp_cyc = (i == 0) ? 2 + int'(WS0) : 2 + int'(WS1);
        PWRITE = w; PADDR = a; PWDATA = d; PSTRB = s; PENABLE = 1'b0;
        if (i == 0) psel0 = 1'b1; else psel1 = 1'b1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        cyc = 0; rdy = 1'b0; rd = 0; err = 0;
        while (!rdy && cyc < 20) begin
            @(negedge PCLK);
            cyc++;
            rdy = (i == 0) ? pready0 : pready1;
            rd  = (i == 0) ? prdata0 : prdata1;
            err = (i == 0) ? pslverr0 : pslverr1;
            if (!rdy) chk("prdata_not_ready", rd, 32'h0);
        end
        exp_err = is_err(a, w);
        if (!rdy) begin
            chk("pready_timeout", 32'(rdy), 32'h1);
        end else begin
            chk("pslverr", 32'(err), 32'(exp_err));
            chk("prdata", rd, (exp_err || w) ? 32'h0 : m_read(i, a));
            chk("xfer_cycles", 32'(cyc), 32'(exp_cyc));
        end
        @(posedge PCLK); #1;
        if (rdy && w && !exp_err) m_write(i, a, d, s);
        PENABLE = 1'b0; psel0 = 1'b0; psel1 = 1'b0;
    endtask

    task automatic wr(input int i, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] r; logic e; int c;
        xfer(i, 1'b1, a, d, s, r, e, c);
    endtask

    task automatic rd(input int i, input logic [11:0] a, output logic [31:0] r);
        logic e; int c;
        xfer(i, 1'b0, a, 32'h0, 4'h0, r, e, c);
    endtask

    logic [31:0] r, wv;
    logic        e;
    int          c;

    initial begin
        PRESET = 1'b1; psel0 = 0; psel1 = 0; PENABLE = 0; PWRITE = 0;
        PADDR = 0; PWDATA = 0; PSTRB = 0; gpio_in = 0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset_pready",  32'(pready0),  32'h0);
        chk("reset_prdata",  prdata0,       32'h0);
        chk("reset_pslverr", 32'(pslverr0), 32'h0);
        chk("reset_gpio_out", 32'(gpio_out0), 32'h0);
        chk("reset_irq",     32'(irq0),     32'h0);
        @(posedge PCLK); #1;
        PRESET = 1'b0; chk_en = 1'b1;

        // Reset in the middle of a write's access phase discards it
        PWRITE = 1; PADDR = 12'h000; PWDATA = 32'hA5; PSTRB = 4'hF; psel0 = 1;
        @(posedge PCLK); #1; PENABLE = 1;
        repeat (3) @(posedge PCLK); #1;
        PRESET = 1'b1; psel0 = 0; PENABLE = 0;
        @(negedge PCLK);
        chk("midwr_pready", 32'(pready0), 32'h0);
        chk("midwr_oe",     32'(gpio_oe0), 32'h0);
        repeat (2) @(posedge PCLK); #1;
        PRESET = 1'b0;
        rd(0, 12'h000, r);
        chk("midwr_dout", r, 32'h0);

        xfer(0, 1'b1, 12'h004, 32'hFF, 4'hF, r, e, c);
        chk("dir_len", 32'(c), 32'd5);
        xfer(0, 1'b1, 12'h000, 32'h5A, 4'hF, r, e, c);
        chk("dout_len", 32'(c), 32'd5);
        chk("gpio_oe_ff",  32'(gpio_oe0),  32'h00FF);
        chk("gpio_out_5a", 32'(gpio_out0), 32'h005A);

        // Set / clear / byte lanes
        wr(0, 12'h000, 32'h00F0);
        wr(0, 12'h018, 32'h0F01);
        wr(0, 12'h01C, 32'h0010);
        rd(0, 12'h000, r);
        chk("set_clr", r, 32'h0FE1);
        wr(0, 12'h000, 32'h0);
        wr(0, 12'h000, 32'hFFFF, 4'b0010);
        rd(0, 12'h000, r);
        chk("byte_lane", r, 32'hFF00);

        // Input synchroniser latency on the zero-wait instance
        fork
            rd(1, 12'h008, r);
            begin @(posedge PCLK); #1; gpio_in = 16'h003C; end
        join
        chk("sync_k1", r, 32'h00);
        gpio_in = 16'h0;
        repeat (4) @(posedge PCLK); #1;
        fork
            rd(1, 12'h008, r);
            begin #2; gpio_in = 16'h003C; end
        join
        chk("sync_k2", r, 32'h3C);

        // Edge interrupts
        gpio_in = 16'h0002;
        repeat (4) @(posedge PCLK); #1;
        wr(0, 12'h014, 32'hFFFF);
        wr(0, 12'h00C, 32'h03);
        wr(0, 12'h010, 32'h02);
        gpio_in = 16'h0001;
        repeat (4) @(posedge PCLK); #1;
        rd(0, 12'h014, r);
        chk("irq_stat_both", r, 32'h03);
        chk("irq_high", 32'(irq0), 32'h1);
        wr(0, 12'h014, 32'h01);
        rd(0, 12'h014, r);
        chk("irq_w1c", r, 32'h02);
        chk("irq_still", 32'(irq0), 32'h1);
        gpio_in = 16'h0003;
        repeat (4) @(posedge PCLK); #1;
        fork
            wr(0, 12'h014, 32'h02);
            begin repeat (3) @(posedge PCLK); #1; gpio_in = 16'h0001; end
        join
        rd(0, 12'h014, r);
        chk("set_wins", r, 32'h02);
        wr(0, 12'h00C, 32'h0);
        chk("irq_masked", 32'(irq0), 32'h0);
        rd(0, 12'h014, r);
        chk("stat_kept", r, 32'h02);
        wr(0, 12'h00C, 32'h03);
        wr(0, 12'h014, 32'h02);
        rd(0, 12'h014, r);
        chk("stat_clear", r, 32'h0);

        // Error responses
        xfer(0, 1'b0, 12'h002, 32'h0, 4'h0, r, e, c);
        chk("err_misalign", 32'(e), 32'h1);
        xfer(0, 1'b0, 12'h040, 32'h0, 4'h0, r, e, c);
        chk("err_high_addr", 32'(e), 32'h1);
        xfer(0, 1'b1, 12'h008, 32'h1234, 4'hF, r, e, c);
        chk("err_wr_din", 32'(e), 32'h1);
        xfer(0, 1'b0, 12'h018, 32'h0, 4'h0, r, e, c);
        chk("err_rd_set", 32'(e), 32'h1);
        chk("err_rd_data", r, 32'h0);
        xfer(0, 1'b1, 12'h001, 32'h1111, 4'hF, r, e, c);
        rd(0, 12'h000, r);
        chk("err_no_change", r, 32'hFF00);
        xfer(0, 1'b1, 12'h000, 32'hFFFF, 4'h0, r, e, c);
        chk("strb0_no_err", 32'(e), 32'h0);
        rd(0, 12'h000, r);
        chk("strb0_no_change", r, 32'hFF00);

        // Width masking on the 8-pin instance
        wr(1, 12'h004, 32'hFFFF_FFFF);
        rd(1, 12'h004, r);
        chk("width_mask", r, 32'hFF);
        wr(1, 12'h004, 32'h0);

        // Back-to-back alternating write/read, zero wait states
        wv = 32'h0;
        for (int j = 0; j < 8; j++) begin
            if (j % 2 == 0) begin
                wv = 32'(8'h5A ^ 8'(j * 37));
                xfer(1, 1'b1, 12'h000, wv, 4'hF, r, e, c);
            end else begin
                xfer(1, 1'b0, 12'h000, 32'h0, 4'h0, r, e, c);
                chk("b2b_read", r, wv);
            end
            chk("b2b_len", 32'(c), 32'd2);
        end

        // Randomised traffic with toggling pins
        pin_rand = 1'b1;
        for (int k = 0; k < 400; k++) begin
            int          i;
            logic        w;
            logic [11:0] a;
            logic [3:0]  s;
            i = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = 12'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) a = a | 12'($urandom_range(1, 3));
                else a = a | 12'(32 << $urandom_range(0, 6));
            end
            s = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            xfer(i, w, a, $urandom, s, r, e, c);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge PCLK);
                #1;
            end
        end
        pin_rand = 1'b0;
        repeat (5) @(posedge PCLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
